rush_log: RTL and testbench

- Consumer at the far end of the rush-hour tracker's outputs: captures the end-of-day `rush_start`/`rush_end` report once per day and stores it in a circular history buffer.
- Lets the attendant scroll back through past days with two buttons; the selected day is presented for the HEX display driver.
- Sits between the rush-hour tracker and the display logic on the parking-lot meter board.

---
 rtl/rush_log.sv | 86 ++++++++
 tb/tb_rush_log.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rush_log.sv
// rush_log: captures the daily rush-hour report into a circular history with scroll-back readout
module rush_log #(
  parameter int DEPTH = 8,
  parameter logic [3:0] DAY_END_HOUR = 4'd8,
  parameter logic [3:0] NO_RUSH = 4'd15,
  parameter logic [3:0] PENDING = 4'd14,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    hour,
  input  logic [3:0]    rush_start,
  input  logic [3:0]    rush_end,
  input  logic          btn_older,
  input  logic          btn_newer,
  output logic [3:0]    rd_start,
  output logic [3:0]    rd_end,
  output logic          rd_incomplete,
  output logic          rd_valid,
  output logic [AW-1:0] rd_offset,
  output logic [CW-1:0] count,
  output logic [CW-1:0] rush_days,
  output logic          overflow
);
  typedef enum logic [1:0] {ARMED, SETTLE, HOLD} state_t;
  state_t r_state, w_next;
  logic [8:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_offset, w_rd_idx;
  logic [CW-1:0] r_count, r_rush_days;
  logic r_overflow, r_older, r_newer;
  logic w_wr, w_full, w_inc, w_new_rush, w_old_rush, w_older, w_newer, w_up, w_dn;
  logic [8:0] w_entry;
  always_comb begin
    w_next = ARMED;
    w_next = (r_state == ARMED) ? ((hour == DAY_END_HOUR) ? SETTLE : ARMED) :
             (r_state == SETTLE) ? HOLD :
             ((hour == DAY_END_HOUR) ? HOLD : ARMED);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ARMED;
    else r_state <= w_next;
  assign w_wr       = r_state == SETTLE;
  assign w_full     = r_count == CW'(DEPTH);
  assign w_inc      = (rush_start != NO_RUSH) && (rush_start != PENDING) && (rush_end == PENDING);
  assign w_new_rush = rush_start != NO_RUSH;
  // the slot about to be overwritten stops counting toward rush_days
  assign w_old_rush = w_full && (r_mem[r_wr_ptr][8:5] != NO_RUSH);
  assign w_older    = btn_older & ~r_older;
  assign w_newer    = btn_newer & ~r_newer;
  assign w_up       = w_older & ~w_newer & (({1'b0, r_rd_offset} + CW'(1)) < r_count);
  assign w_dn       = w_newer & ~w_older & (r_rd_offset != '0);
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr_ptr] <= {rush_start, rush_end, w_inc};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_offset <= '0;
      r_count     <= '0;
      r_rush_days <= '0;
      r_overflow  <= 1'b0;
      r_older     <= 1'b0;
      r_newer     <= 1'b0;
    end else begin
      r_older <= btn_older;
      r_newer <= btn_newer;
      if (w_wr) begin
        r_wr_ptr    <= r_wr_ptr + AW'(1);
        r_rd_offset <= '0;
        r_count     <= r_count + CW'(!w_full);
        r_rush_days <= r_rush_days + CW'(w_new_rush) - CW'(w_old_rush);
        if (w_full) r_overflow <= 1'b1;
      end else if (w_up) r_rd_offset <= r_rd_offset + AW'(1);
      else if (w_dn) r_rd_offset <= r_rd_offset - AW'(1);
    end
  assign w_rd_idx      = r_wr_ptr - AW'(1) - r_rd_offset;
  assign w_entry       = r_mem[w_rd_idx];
  assign rd_valid      = r_count != '0;
  assign rd_start      = rd_valid ? w_entry[8:5] : PENDING;
  assign rd_end        = rd_valid ? w_entry[4:1] : PENDING;
  assign rd_incomplete = rd_valid & w_entry[0];
  assign rd_offset     = r_rd_offset;
  assign count         = r_count;
  assign rush_days     = r_rush_days;
  assign overflow      = r_overflow;
endmodule

// File: tb/tb_rush_log.sv
// tb_rush_log: directed stimulus with a day-list model and literal spot checks
module tb_rush_log;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] hour = 4'd0, rush_start = 4'd14, rush_end = 4'd14;
  logic btn_older = 1'b0, btn_newer = 1'b0;
  logic [3:0] rd_start, rd_end;
  logic rd_incomplete, rd_valid, overflow;
  logic [2:0] rd_offset;
  logic [3:0] count, rush_days;
  int checks = 0, failures = 0;
  logic [3:0] days_s [$], days_e [$];
  int m_off = 0;
  bit m_due = 0, m_in = 0, m_po = 0, m_pn = 0;
  rush_log #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .hour(hour), .rush_start(rush_start), .rush_end(rush_end),
    .btn_older(btn_older), .btn_newer(btn_newer), .rd_start(rd_start), .rd_end(rd_end),
    .rd_incomplete(rd_incomplete), .rd_valid(rd_valid), .rd_offset(rd_offset),
    .count(count), .rush_days(rush_days), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", n, act, exp);
    end
  endtask
  function automatic int m_cnt();
    return (days_s.size() > DEPTH) ? DEPTH : days_s.size();
  endfunction
  function automatic int m_rush();
    int r = 0;
    for (int i = days_s.size() - m_cnt(); i < days_s.size(); i++) r += (days_s[i] != 4'd15);
    return r;
  endfunction
  // model: a list of every recorded day; the visible window is its last DEPTH entries
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      days_s.delete(); days_e.delete();
      m_due = 0; m_in = 0; m_off = 0; m_po = 0; m_pn = 0;
    end else begin
      bit eo, en;
      eo = btn_older && !m_po;
      en = btn_newer && !m_pn;
      m_po = btn_older;
      m_pn = btn_newer;
      if (m_due) begin
        days_s.push_back(rush_start); days_e.push_back(rush_end);
        m_due = 0; m_in = 1; m_off = 0;
      end else begin
        if (!m_in && hour == 4'd8) m_due = 1;
        else if (m_in && hour != 4'd8) m_in = 0;
        if (eo && !en && m_off < m_cnt() - 1) m_off++;
        else if (en && !eo && m_off > 0) m_off--;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      int c, i;
      logic [3:0] es, ee;
      c = m_cnt();
      i = days_s.size() - 1 - m_off;
      es = (c == 0) ? 4'd14 : days_s[i];
      ee = (c == 0) ? 4'd14 : days_e[i];
      chk("m_count", count, c);
      chk("m_valid", rd_valid, c != 0);
      chk("m_start", rd_start, es);
      chk("m_end", rd_end, ee);
      chk("m_incomplete", rd_incomplete, c != 0 && es != 4'd15 && es != 4'd14 && ee == 4'd14);
      chk("m_offset", rd_offset, m_off);
      chk("m_rush_days", rush_days, m_rush());
      chk("m_overflow", overflow, days_s.size() > DEPTH);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic day(input logic [3:0] s, input logic [3:0] e);
    rush_start = s; rush_end = e; hour = 4'd8;
    repeat (3) tick();
    hour = 4'd0; rush_start = 4'd14; rush_end = 4'd14;
    repeat (2) tick();
  endtask
  task automatic press(input logic o, input logic n);
    btn_older = o; btn_newer = n;
    tick();
    btn_older = 1'b0; btn_newer = 1'b0;
    tick();
  endtask
  initial begin
    #1;
    chk("rst_count", count, 0);
    chk("rst_offset", rd_offset, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int h = 0; h < 8; h++) begin
      hour = 4'(h);
      tick();
    end
    chk("idle_valid", rd_valid, 0);
    chk("idle_start", rd_start, 14);
    chk("idle_end", rd_end, 14);
    chk("idle_count", count, 0);
    chk("idle_rush_days", rush_days, 0);
    chk("idle_overflow", overflow, 0);
    rush_start = 4'd2; rush_end = 4'd4; hour = 4'd8;
    tick();
    chk("lat_edge1_count", count, 0);
    tick();
    chk("lat_edge2_count", count, 1);
    chk("d1_start", rd_start, 2);
    chk("d1_end", rd_end, 4);
    chk("d1_incomplete", rd_incomplete, 0);
    chk("d1_rush_days", rush_days, 1);
    repeat (5) tick();
    chk("hold_count", count, 1);
    hour = 4'd0;
    repeat (2) tick();
    day(4'd15, 4'd15);
    day(4'd3, 4'd14);
    chk("d3_count", count, 3);
    chk("d3_start", rd_start, 3);
    chk("d3_end", rd_end, 14);
    chk("d3_incomplete", rd_incomplete, 1);
    press(1, 0);
    chk("back1_offset", rd_offset, 1);
    chk("back1_start", rd_start, 15);
    chk("back1_end", rd_end, 15);
    chk("back1_rush_days", rush_days, 2);
    repeat (4) press(1, 0);
    chk("sat_old_offset", rd_offset, 2);
    press(1, 1);
    chk("both_offset", rd_offset, 2);
    repeat (3) press(0, 1);
    chk("sat_new_offset", rd_offset, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 1; k <= 9; k++) day(4'(k), 4'(k + 1));
    chk("ovf_count", count, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_rush_days", rush_days, 8);
    repeat (7) press(1, 0);
    chk("ovf_oldest_offset", rd_offset, 7);
    chk("ovf_oldest_start", rd_start, 2);
    day(4'd15, 4'd15);
    chk("ovf10_rush_days", rush_days, 7);
    chk("ovf10_start", rd_start, 15);
    press(1, 0);
    chk("coll_pre_offset", rd_offset, 1);
    rush_start = 4'd6; rush_end = 4'd7; hour = 4'd8;
    tick();
    btn_older = 1'b1;
    tick();
    chk("coll_offset", rd_offset, 0);
    chk("coll_start", rd_start, 6);
    btn_older = 1'b0;
    tick();
    hour = 4'd0;
    repeat (2) tick();
    rush_start = 4'd5; rush_end = 4'd6; hour = 4'd8;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_valid", rd_valid, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_rush_days", rush_days, 0);
    chk("midrst_start", rd_start, 14);
    hour = 4'd0;
    #3;
    rst_n = 1'b1;
    repeat (4) tick();
    chk("postrst_count", count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
